db_cbf_ram_ctrl: RTL and testbench

DB_CBF_RAM_CTRL -- requirements
Module: db_cbf_ram_ctrl

---
 rtl/db_cbf_ram_ctrl_pkg.sv | 28 ++
 rtl/db_cbf_ram_ctrl.sv | 132 +++++++++++++
 tb/tb_db_cbf_ram_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_cbf_ram_ctrl_pkg.sv
// Shared definitions for the CBF RAM controller: default geometry, FSM encoding
// and the write-over-read arbitration rule with its starvation override.
package db_cbf_ram_ctrl_pkg;

  localparam int CBF_ADDR_W = 6;
  localparam int CBF_DATA_W = 16;

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_CLEAR = 1'b1
  } cbf_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_WR   = 2'b01,
    GNT_RD   = 2'b10
  } cbf_gnt_e;

  // Writes win by default; a read that has waited STARVE_MAX write grants wins instead.
  function automatic cbf_gnt_e cbf_arbitrate(input logic wr_req,
                                             input logic rd_req,
                                             input logic starved);
    if (rd_req && (!wr_req || starved)) return GNT_RD;
    if (wr_req)                         return GNT_WR;
    return GNT_NONE;
  endfunction

endpackage

// File: rtl/db_cbf_ram_ctrl.sv
// CBF RAM controller: arbitrates one write and one read port onto an external
// single-port RAM, with a full zero-fill sweep and a fixed two-cycle read pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_SERVE | arbitrate write/read requests, one RAM access per cycle
// ST_CLEAR | write zero to every address, one per cycle; requests held off
module db_cbf_ram_ctrl
  import db_cbf_ram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = CBF_ADDR_W,
  parameter int DATA_W     = CBF_DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start_i,
  output logic              clr_done_o,
  output logic              busy_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_adr_i,
  input  logic [DATA_W-1:0] wr_dat_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_adr_i,
  output logic              rd_ack_o,
  output logic              rd_val_o,
  output logic [DATA_W-1:0] rd_dat_o,
  output logic              ram_cen_o,
  output logic              ram_wen_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [DATA_W-1:0] ram_wr_dat_o,
  input  logic [DATA_W-1:0] ram_rd_dat_i
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  cbf_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_adr_q, clr_adr_d;
  logic [SW-1:0]     starve_q;
  logic              clr_done_q;
  logic              rd_pend_q;
  logic              rd_val_q;
  logic [DATA_W-1:0] rd_dat_q;
  logic              clr_last;
  logic              starved;
  cbf_gnt_e          gnt;

  assign starved = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d      = state_q;
    clr_adr_d    = clr_adr_q;
    clr_last     = 1'b0;
    gnt          = GNT_NONE;
    busy_o       = 1'b0;
    wr_ack_o     = 1'b0;
    rd_ack_o     = 1'b0;
    ram_cen_o    = 1'b1;
    ram_wen_o    = 1'b1;
    ram_adr_o    = '0;
    ram_wr_dat_o = '0;
    if (!rst) begin
      unique case (state_q)
        ST_SERVE: begin
          if (clr_start_i) begin
            state_d   = ST_CLEAR;
            clr_adr_d = '0;
          end else begin
            gnt = cbf_arbitrate(wr_req_i, rd_req_i, starved);
          end
        end
        ST_CLEAR: begin
          busy_o       = 1'b1;
          ram_cen_o    = 1'b0;
          ram_wen_o    = 1'b0;
          ram_adr_o    = clr_adr_q;
          clr_adr_d    = clr_adr_q + 1'b1;
          if (clr_adr_q == '1) begin
            state_d  = ST_SERVE;
            clr_last = 1'b1;
          end
        end
        default: state_d = ST_SERVE;
      endcase

      unique case (gnt)
        GNT_WR: begin
          wr_ack_o     = 1'b1;
          ram_cen_o    = 1'b0;
          ram_wen_o    = 1'b0;
          ram_adr_o    = wr_adr_i;
          ram_wr_dat_o = wr_dat_i;
        end
        GNT_RD: begin
          rd_ack_o  = 1'b1;
          ram_cen_o = 1'b0;
          ram_adr_o = rd_adr_i;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SERVE;
      clr_adr_q  <= '0;
      starve_q   <= '0;
      clr_done_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_val_q   <= 1'b0;
      rd_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      clr_adr_q  <= clr_adr_d;
      clr_done_q <= clr_last;
      rd_pend_q  <= (gnt == GNT_RD);
      rd_val_q   <= rd_pend_q;
      if (rd_pend_q) rd_dat_q <= ram_rd_dat_i;
      // Counter only grows while a read is actually being passed over.
      if (gnt == GNT_RD || !rd_req_i)          starve_q <= '0;
      else if (gnt == GNT_WR && !starved)      starve_q <= starve_q + 1'b1;
    end
  end

  // Registered outputs are forced idle for the whole reset window, not just after it.
  assign clr_done_o = clr_done_q & ~rst;
  assign rd_val_o   = rd_val_q & ~rst;
  assign rd_dat_o   = rst ? '0 : rd_dat_q;

endmodule

// File: tb/tb_db_cbf_ram_ctrl.sv
// Directed bench for db_cbf_ram_ctrl with a behavioural single-port RAM model
// attached to the ram_* ports.
module tb_db_cbf_ram_ctrl;

  localparam int AW = 6;
  localparam int DW = 16;
  localparam int NW = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr_start_i, clr_done_o, busy_o;
  logic          wr_req_i, wr_ack_o, rd_req_i, rd_ack_o, rd_val_o;
  logic          ram_cen_o, ram_wen_o;
  logic [AW-1:0] wr_adr_i, rd_adr_i, ram_adr_o;
  logic [DW-1:0] wr_dat_i, rd_dat_o, ram_wr_dat_o, ram_rd_dat_i;
  logic [DW-1:0] mem [NW];
  logic          mem_fill;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  db_cbf_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .clr_start_i(clr_start_i), .clr_done_o(clr_done_o), .busy_o(busy_o),
    .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_dat_i(wr_dat_i), .wr_ack_o(wr_ack_o),
    .rd_req_i(rd_req_i), .rd_adr_i(rd_adr_i), .rd_ack_o(rd_ack_o),
    .rd_val_o(rd_val_o), .rd_dat_o(rd_dat_o),
    .ram_cen_o(ram_cen_o), .ram_wen_o(ram_wen_o), .ram_adr_o(ram_adr_o),
    .ram_wr_dat_o(ram_wr_dat_o), .ram_rd_dat_i(ram_rd_dat_i)
  );

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < NW; i++) mem[i] <= 16'hDEAD;
    end else if (!ram_cen_o) begin
      if (!ram_wen_o) mem[ram_adr_o] <= ram_wr_dat_o;
      else            ram_rd_dat_i   <= mem[ram_adr_o];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    clr_start_i = 1'b0;
    wr_req_i = 1'b0; wr_adr_i = '0; wr_dat_i = '0;
    rd_req_i = 1'b0; rd_adr_i = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    wr_req_i = 1'b1; wr_adr_i = a; wr_dat_i = d; ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      sample();
      ok = wr_ack_o;
      step();
    end
    wr_req_i = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int lat, output logic [DW-1:0] d,
                         output bit ok);
    bit acked = 1'b0;
    rd_req_i = 1'b1; rd_adr_i = a; lat = 0; d = '0;
    for (int k = 0; k < 100 && !acked; k++) begin
      sample();
      acked = rd_ack_o;
      step();
    end
    rd_req_i = 1'b0;
    for (int k = 1; k <= 10 && acked && lat == 0; k++) begin
      sample();
      if (rd_val_o) begin lat = k; d = rd_dat_o; end
      step();
    end
    ok = acked && (lat != 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_fill = 1'b1;
    clr_start_i = 1'b1; wr_req_i = 1'b1; rd_req_i = 1'b1;
    wr_adr_i = 6'd3; wr_dat_i = 16'h1234; rd_adr_i = 6'd4;
    step(); step();
    sample();
    n_vec++; if (wr_ack_o !== 1'b0)  begin n_err++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack_o); end
    n_vec++; if (rd_ack_o !== 1'b0)  begin n_err++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack_o); end
    n_vec++; if (ram_cen_o !== 1'b1) begin n_err++; $display("FAIL reset_cen: got %b want 1", ram_cen_o); end
    n_vec++; if (ram_wen_o !== 1'b1) begin n_err++; $display("FAIL reset_wen: got %b want 1", ram_wen_o); end
    n_vec++; if (busy_o !== 1'b0)    begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_vec++; if (clr_done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", clr_done_o); end
    n_vec++; if (rd_val_o !== 1'b0)  begin n_err++; $display("FAIL reset_rd_val: got %b want 0", rd_val_o); end
    n_vec++; if (rd_dat_o !== 16'h0) begin n_err++; $display("FAIL reset_rd_dat: got %h want 0000", rd_dat_o); end
    step();
    idle(); mem_fill = 1'b0; rst = 1'b0;
    step();
  endtask

  task automatic test_clear();
    bit bad; bit ok; int lat; logic [DW-1:0] d;
    logic [AW-1:0] radr [3] = '{6'd0, 6'd33, 6'd63};
    clr_start_i = 1'b1;
    sample();
    n_vec++;
    if (busy_o !== 1'b0 || ram_cen_o !== 1'b1) begin
      n_err++; $display("FAIL clear_start_cycle: busy=%b cen=%b want 0 1", busy_o, ram_cen_o);
    end
    step();
    clr_start_i = 1'b0;
    for (int c = 1; c <= NW; c++) begin
      sample();
      n_vec++;
      if (busy_o !== 1'b1 || ram_cen_o !== 1'b0 || ram_wen_o !== 1'b0 ||
          ram_adr_o !== AW'(c - 1) || ram_wr_dat_o !== 16'h0 || clr_done_o !== 1'b0) begin
        n_err++;
        $display("FAIL clear_cycle%0d: busy=%b cen=%b wen=%b adr=%0d dat=%h done=%b want 1 0 0 %0d 0000 0",
                 c, busy_o, ram_cen_o, ram_wen_o, ram_adr_o, ram_wr_dat_o, clr_done_o, c - 1);
      end
      step();
    end
    sample();
    n_vec++;
    if (clr_done_o !== 1'b1 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL clear_done_pulse: done=%b busy=%b want 1 0", clr_done_o, busy_o);
    end
    step();
    sample();
    n_vec++;
    if (clr_done_o !== 1'b0) begin n_err++; $display("FAIL clear_done_width: got %b want 0", clr_done_o); end
    step();
    bad = 1'b0;
    for (int i = 0; i < NW; i++) if (mem[i] !== 16'h0) bad = 1'b1;
    n_vec++; if (bad) begin n_err++; $display("FAIL clear_ram_zero: nonzero word left, want all 0000"); end
    for (int i = 0; i < 3; i++) begin
      do_read(radr[i], lat, d, ok);
      n_vec++;
      if (!ok || d !== 16'h0) begin
        n_err++; $display("FAIL clear_readback%0d: ok=%b dat=%h want 1 0000", radr[i], ok, d);
      end
    end
  endtask

  task automatic test_write_read();
    bit ok; int lat; logic [DW-1:0] d;
    do_write(6'd17, 16'hA5C3, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wr17_ack: got no ack want ack"); end
    do_read(6'd17, lat, d, ok);
    n_vec++; if (!ok || lat != 2) begin n_err++; $display("FAIL rd17_latency: got %0d want 2", lat); end
    n_vec++; if (d !== 16'hA5C3) begin n_err++; $display("FAIL rd17_data: got %h want a5c3", d); end
    sample();
    n_vec++;
    if (rd_val_o !== 1'b0 || rd_dat_o !== 16'hA5C3) begin
      n_err++; $display("FAIL rd17_hold: val=%b dat=%h want 0 a5c3", rd_val_o, rd_dat_o);
    end
    step();
  endtask

  task automatic test_collision();
    wr_req_i = 1'b1; wr_adr_i = 6'd5; wr_dat_i = 16'h0F0F;
    rd_req_i = 1'b1; rd_adr_i = 6'd5;
    sample();
    n_vec++;
    if (wr_ack_o !== 1'b1 || rd_ack_o !== 1'b0 || ram_wen_o !== 1'b0 ||
        ram_adr_o !== 6'd5 || ram_wr_dat_o !== 16'h0F0F) begin
      n_err++; $display("FAIL coll_write_first: wack=%b rack=%b wen=%b adr=%0d dat=%h want 1 0 0 5 0f0f",
                        wr_ack_o, rd_ack_o, ram_wen_o, ram_adr_o, ram_wr_dat_o);
    end
    step();
    wr_req_i = 1'b0;
    sample();
    n_vec++;
    if (rd_ack_o !== 1'b1 || ram_cen_o !== 1'b0 || ram_wen_o !== 1'b1 || ram_adr_o !== 6'd5) begin
      n_err++; $display("FAIL coll_read_next: rack=%b cen=%b wen=%b adr=%0d want 1 0 1 5",
                        rd_ack_o, ram_cen_o, ram_wen_o, ram_adr_o);
    end
    step();
    rd_req_i = 1'b0;
    sample();
    n_vec++; if (rd_val_o !== 1'b0) begin n_err++; $display("FAIL coll_val_early: got %b want 0", rd_val_o); end
    step();
    sample();
    n_vec++;
    if (rd_val_o !== 1'b1 || rd_dat_o !== 16'h0F0F) begin
      n_err++; $display("FAIL coll_data: val=%b dat=%h want 1 0f0f", rd_val_o, rd_dat_o);
    end
    step();
  endtask

  task automatic test_starve();
    int nw = 0; bit got = 1'b0;
    rd_req_i = 1'b1; rd_adr_i = 6'd9;
    wr_req_i = 1'b1; wr_adr_i = 6'd20; wr_dat_i = 16'd100;
    for (int k = 0; k < 20 && !got; k++) begin
      sample();
      if (rd_ack_o) begin
        got = 1'b1;
        n_vec++;
        if (wr_ack_o !== 1'b0) begin n_err++; $display("FAIL starve_single_access: wack=%b want 0", wr_ack_o); end
      end else if (wr_ack_o) begin
        nw++;
      end
      step();
      wr_dat_i = wr_dat_i + 16'd1;
    end
    rd_req_i = 1'b0;
    n_vec++;
    if (!got || nw != 4) begin n_err++; $display("FAIL starve_count: read_acked=%b writes=%0d want 1 4", got, nw); end
    sample();
    n_vec++; if (wr_ack_o !== 1'b1) begin n_err++; $display("FAIL starve_write_resume: got %b want 1", wr_ack_o); end
    step();
    idle();
    step(); step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [DW-1:0] wdat [3] = '{16'h1111, 16'h2222, 16'h3333};
    logic          ev   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [DW-1:0] ed   [6] = '{16'h0, 16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h0};
    for (int i = 0; i < 3; i++) do_write(AW'(i + 1), wdat[i], ok);
    for (int c = 0; c < 6; c++) begin
      rd_req_i = (c < 3); rd_adr_i = AW'(c + 1);
      sample();
      n_vec++;
      if (rd_ack_o !== (c < 3) || rd_val_o !== ev[c] || (ev[c] && rd_dat_o !== ed[c])) begin
        n_err++; $display("FAIL b2b_cycle%0d: ack=%b val=%b dat=%h want %b %b %h",
                          c, rd_ack_o, rd_val_o, rd_dat_o, (c < 3), ev[c], ed[c]);
      end
      step();
    end
    idle();
  endtask

  task automatic test_ignored_start();
    bit bad = 1'b0;
    clr_start_i = 1'b1;
    wr_req_i = 1'b1; wr_adr_i = 6'd7; wr_dat_i = 16'h7777;
    sample();
    n_vec++; if (wr_ack_o !== 1'b0) begin n_err++; $display("FAIL ign_start_no_grant: got %b want 0", wr_ack_o); end
    step();
    clr_start_i = 1'b0;
    for (int c = 1; c <= NW; c++) begin
      clr_start_i = (c == 20);
      sample();
      n_vec++;
      if (busy_o !== 1'b1 || wr_ack_o !== 1'b0 || rd_ack_o !== 1'b0 || ram_adr_o !== AW'(c - 1)) begin
        n_err++; $display("FAIL ign_cycle%0d: busy=%b wack=%b rack=%b adr=%0d want 1 0 0 %0d",
                          c, busy_o, wr_ack_o, rd_ack_o, ram_adr_o, c - 1);
      end
      step();
    end
    clr_start_i = 1'b0;
    sample();
    n_vec++;
    if (clr_done_o !== 1'b1 || wr_ack_o !== 1'b1 || ram_adr_o !== 6'd7) begin
      n_err++; $display("FAIL ign_serve_grant: done=%b wack=%b adr=%0d want 1 1 7", clr_done_o, wr_ack_o, ram_adr_o);
    end
    step();
    wr_req_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      sample();
      if (busy_o !== 1'b0) bad = 1'b1;
      step();
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL ign_no_restart: busy seen high, want 0"); end
    n_vec++; if (mem[7] !== 16'h7777) begin n_err++; $display("FAIL ign_write_data: got %h want 7777", mem[7]); end
  endtask

  task automatic test_abort();
    bit bad = 1'b0; bit ok; int lat; logic [DW-1:0] d;
    clr_start_i = 1'b1;
    step();
    clr_start_i = 1'b0;
    for (int c = 1; c <= 30; c++) step();
    sample();
    n_vec++; if (ram_adr_o !== 6'd30) begin n_err++; $display("FAIL abort_at30: adr=%0d want 30", ram_adr_o); end
    rst = 1'b1;
    step();
    sample();
    n_vec++;
    if (busy_o !== 1'b0 || ram_cen_o !== 1'b1 || clr_done_o !== 1'b0) begin
      n_err++; $display("FAIL abort_in_reset: busy=%b cen=%b done=%b want 0 1 0", busy_o, ram_cen_o, clr_done_o);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (busy_o !== 1'b0 || clr_done_o !== 1'b0 || ram_cen_o !== 1'b1) bad = 1'b1;
      step();
    end
    n_vec++; if (bad) begin n_err++; $display("FAIL abort_no_done: sweep activity after reset, want none"); end
    do_write(6'd40, 16'h1234, ok);
    do_read(6'd40, lat, d, ok);
    n_vec++;
    if (!ok || lat != 2 || d !== 16'h1234) begin
      n_err++; $display("FAIL abort_wr_rd: ok=%b lat=%0d dat=%h want 1 2 1234", ok, lat, d);
    end
  endtask

  initial begin
    idle();
    rst = 1'b1; mem_fill = 1'b1;
    test_reset();
    test_clear();
    test_write_read();
    test_collision();
    test_starve();
    test_back_to_back();
    test_ignored_start();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
